// File: rtl/vc_test_pkg.sv
// Shared constants and helpers for the delayed test sink and its LFSR.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   C_LFSR_SEED  - reset value of the random source
//   C_LFSR_TAPS  - Galois feedback mask for x^32 + x^22 + x^2 + x + 1
//   lfsr_next()  - one Galois step
//   delay_mod()  - random value reduced to 0..max_delay at 33-bit width
package vc_test_pkg;

    localparam logic [31:0] C_LFSR_SEED = 32'hACE1_1234;
    // x^32 is the implicit shift-out; bits 22, 2, 1, 0 are the remaining terms.
    localparam logic [31:0] C_LFSR_TAPS = 32'h0040_0007;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = {cur[30:0], 1'b0};
        if (cur[31]) begin
            nxt = nxt ^ C_LFSR_TAPS;
        end
        return nxt;
    endfunction

    // Divisor is max_delay + 1 computed in 33 bits, so an all-ones max_delay
    // yields 2^32 rather than wrapping to a zero divisor.
    function automatic logic [31:0] delay_mod(input logic [31:0] rnd,
                                              input logic [31:0] max_delay);
        return 32'({1'b0, rnd} % ({1'b0, max_delay} + 33'd1));
    endfunction

endpackage

// File: rtl/vc_test_lfsr32.sv
// 32-bit Galois LFSR used as the random source for ready-withholding delays.
// Latency: out reflects the new state one cycle after en is sampled high.
// Backpressure: none; the state only advances when en is high.
//
// Ports: clk, reset (sync, active-high, loads C_LFSR_SEED), en (advance one
// step), out[31:0] (current state).
module vc_test_lfsr32
    import vc_test_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= C_LFSR_SEED;
        end else if (en) begin
            out <= lfsr_next(out);
        end
    end

endmodule

// File: rtl/vc_test_delay_sink.sv
// Test sink: accepts messages with random ready-withholding and checks them
// against a preloaded expected-message memory m.
// Latency: rdy, done, error and err_index update one cycle after an xfer.
// Backpressure: after each xfer rdy is withheld for lfsr % (max_delay+1)
// cycles; rdy stays low for good once done.
//
// Ports: clk, reset (sync, active-high), max_delay[31:0], val/rdy/msg
// (upstream handshake), done (all expected messages consumed), error (sticky
// mismatch), err_index[31:0] (index of first mismatch).
// Build option: define VC_TEST_DELAY_SINK_DISPLAY_EN to log every xfer and
// print each mismatch; check results are identical either way.
module vc_test_delay_sink
    import vc_test_pkg::*;
#(
    parameter int p_msg_nbits = 1,
    parameter int p_num_msgs  = 1024
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            max_delay,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_msg_nbits-1:0] msg,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            err_index
);

    localparam int AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

    // Expected messages, written only by the testbench through hierarchy.
    logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];

    logic [31:0]            index;
    logic [31:0]            cnt;
    logic [31:0]            lfsr_out;
    logic [31:0]            cnt_load;
    logic [p_msg_nbits-1:0] m_cur;
    logic                   in_range;
    logic                   xfer;
    logic                   mismatch;

    vc_test_lfsr32 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (xfer),
        .out   (lfsr_out)
    );

    assign in_range = (index < 32'(p_num_msgs));
    assign m_cur    = in_range ? m[index[AW-1:0]] : '0;

    // An entry with any unknown bit terminates the expected stream early.
    assign done     = !in_range || $isunknown(m_cur);
    assign rdy      = (cnt == 32'd0) && !done;
    assign xfer     = val && rdy;

    // Case-inequality so X/Z on the received message is never a match.
    assign mismatch = (msg !== m_cur);
    assign cnt_load = delay_mod(lfsr_out, max_delay);

    always_ff @(posedge clk) begin
        if (reset) begin
            index <= 32'd0;
        end else if (xfer) begin
            index <= index + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 32'd0;
        end else if (xfer) begin
            cnt <= cnt_load;
        end else if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
        end
    end

    // Only the first mismatch is recorded; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            error     <= 1'b0;
            err_index <= 32'd0;
        end else if (xfer && mismatch && !error) begin
            error     <= 1'b1;
            err_index <= index;
        end
    end

`ifdef VC_TEST_DELAY_SINK_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset && xfer) begin
            $display("vc_test_delay_sink: verbose xfer index=%0d msg=%h", index, msg);
            if (mismatch) begin
                $display("vc_test_delay_sink: mismatch index=%0d expected=%h received=%h",
                         index, m_cur, msg);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_test_delay_sink.sv
// Self-checking bench for vc_test_delay_sink: directed scenarios plus a
// per-cycle reference model of index/done/error/err_index and the delay bound.
// Latency: n/a. Backpressure: driver holds each message until rdy is seen.
module tb_vc_test_delay_sink;

    localparam int N = 50;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  max_delay;
    logic         val;
    logic         rdy;
    logic [W-1:0] msg;
    logic         done;
    logic         error;
    logic [31:0]  err_index;

    int checks   = 0;
    int failures = 0;

    vc_test_delay_sink #(.p_msg_nbits(W), .p_num_msgs(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .max_delay (max_delay),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] exp_m [0:N-1];
    int           midx      = 0;
    logic         merr      = 1'b0;
    int           meidx     = 0;
    logic [31:0]  md_loaded = 32'd0;
    int           lowrun    = 0;
    logic         mvalid    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic model_done();
        if (midx >= N) return 1'b1;
        return $isunknown(exp_m[midx]);
    endfunction

    // Consume handshakes with the pre-edge values of val/rdy/msg.
    always @(posedge clk) begin
        if (reset) begin
            midx = 0; merr = 1'b0; meidx = 0; md_loaded = 32'd0; lowrun = 0;
            mvalid = 1'b1;
        end else if (mvalid && val === 1'b1 && rdy === 1'b1) begin
            if (midx < N && msg !== exp_m[midx] && !merr) begin
                merr  = 1'b1;
                meidx = midx;
            end
            midx++;
            md_loaded = max_delay;
        end
    end

    // Outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (mvalid) begin
            logic md;
            md = model_done();
            chk("done", {31'd0, done}, {31'd0, md});
            chk("error", {31'd0, error}, {31'd0, merr});
            chk("err_index", err_index, 32'(meidx));
            if (md) begin
                chk("rdy_when_done", {31'd0, rdy}, 32'd0);
            end else if (md_loaded == 32'd0) begin
                chk("rdy_zero_delay", {31'd0, rdy}, 32'd1);
            end
            if (rdy === 1'b0 && !md) lowrun++;
            else lowrun = 0;
            if (md_loaded < 32'd1000) begin
                chk("gap_bound", {31'd0, (32'(lowrun) <= md_loaded)}, 32'd1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic ld(input int i, input logic [W-1:0] v);
        exp_m[i] = v;
        dut.m[i] = v;
    endtask

    // First n entries get a known pattern; the rest are the unknown sentinel.
    task automatic fill(input int n);
        for (int i = 0; i < N; i++) begin
            if (i < n) ld(i, 8'(i * 13 + 5));
            else       ld(i, 8'bxxxx_xxxx);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the xfer.
    task automatic send(input logic [W-1:0] v, output int gap);
        val = 1'b1;
        msg = v;
        gap = 0;
        while (rdy !== 1'b1 && gap < 2000) begin
            @(negedge clk);
            gap++;
        end
        if (gap >= 2000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=rdy_low required=rdy_high at %0t", $time);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int g;
    int gsum;
    int gmax;
    int gaps1 [$];
    int gaps2 [$];
    int diffs;

    initial begin
        reset     = 1'b1;
        val       = 1'b0;
        msg       = '0;
        max_delay = 32'd0;
        fill(3);
        ld(0, 8'h01); ld(1, 8'h02); ld(2, 8'h03);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("reset_rdy", {31'd0, rdy}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        chk("reset_err_index", err_index, 32'd0);

        // Zero delay: three back-to-back xfers
        gsum = 0;
        for (int k = 0; k < 3; k++) begin
            send(exp_m[k], g);
            gsum += g;
        end
        val = 1'b0;
        chk("zero_delay_gaps", 32'(gsum), 32'd0);
        chk("zero_delay_error", {31'd0, error}, 32'd0);
        repeat (2) @(negedge clk);

        // max_delay=4, 50 messages, rerun must repeat the gap sequence
        fill(N);
        max_delay = 32'd4;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            gmax = 0;
            for (int k = 0; k < N; k++) begin
                send(exp_m[k], g);
                if (pass == 0) gaps1.push_back(g);
                else           gaps2.push_back(g);
                if (g > gmax) gmax = g;
            end
            val = 1'b0;
            chk("delay4_max_gap_ok", {31'd0, (gmax <= 4)}, 32'd1);
            chk("delay4_done", {31'd0, done}, 32'd1);
            chk("delay4_error", {31'd0, error}, 32'd0);
            chk("delay4_rdy", {31'd0, rdy}, 32'd0);
        end
        diffs = 0;
        gsum  = 0;
        for (int k = 0; k < N; k++) begin
            if (gaps1[k] != gaps2[k]) diffs++;
            gsum += gaps1[k];
        end
        chk("rerun_gap_diffs", 32'(diffs), 32'd0);
        chk("delay4_some_stall", {31'd0, (gsum > 0)}, 32'd1);

        // Mismatches at index 2 and 5; first one is captured
        fill(N);
        ld(2, 8'hAA);
        max_delay = 32'd2;
        do_reset();
        for (int k = 0; k < N; k++) begin
            if (k == 2)      send(8'hAB, g);
            else if (k == 5) send(8'hFF, g);
            else             send(exp_m[k], g);
        end
        val = 1'b0;
        chk("mm_error", {31'd0, error}, 32'd1);
        chk("mm_err_index", err_index, 32'd2);
        chk("mm_done", {31'd0, done}, 32'd1);

        // Unknown bits on msg mismatch m[0]=0
        fill(N);
        ld(0, 8'h00);
        max_delay = 32'd0;
        do_reset();
        send(8'bx000_0001, g);
        val = 1'b0;
        chk("xmsg_error", {31'd0, error}, 32'd1);
        chk("xmsg_err_index", err_index, 32'd0);

        // Reset mid-stream, then replay all 10
        fill(10);
        max_delay = 32'd3;
        do_reset();
        for (int k = 0; k < 3; k++) send(exp_m[k], g);
        do_reset();
        chk("midrst_rdy", {31'd0, rdy}, 32'd1);
        chk("midrst_error", {31'd0, error}, 32'd0);
        for (int k = 0; k < 10; k++) send(exp_m[k], g);
        val = 1'b0;
        chk("midrst_final_error", {31'd0, error}, 32'd0);
        chk("midrst_index", dut.index, 32'd10);

        // All-ones max_delay: huge withhold, no unknowns, reset recovers
        fill(N);
        max_delay = 32'hFFFF_FFFF;
        do_reset();
        send(exp_m[0], g);
        val = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("maxdly_rdy_low", {31'd0, rdy}, 32'd0);
            chk("maxdly_cnt_known", {31'd0, $isunknown(dut.cnt)}, 32'd0);
            @(negedge clk);
        end
        do_reset();
        chk("maxdly_rdy_after_reset", {31'd0, rdy}, 32'd1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
